gpu_fill_cmd_loader: RTL and testbench



---
 rtl/gpu_fill_cmd_loader.sv | 115 +++++++++++
 tb/tb_gpu_fill_cmd_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_fill_cmd_loader.sv
// gpu_fill_cmd_loader
// Reads the three-word fill-rectangle packet from the command FIFO. Each word
// is latched into the fill engine's setup registers with the PSX coordinate
// masking and width rounding applied. The block then pulses the fill engine's
// start and holds the registers stable until the engine reports completion.
module gpu_fill_cmd_loader (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_start,
    input  logic [31:0]        i_fifoData,
    input  logic               i_fifoEmpty,
    output logic               o_fifoPop,
    output logic [7:0]         o_RegR0,
    output logic [7:0]         o_RegG0,
    output logic [7:0]         o_RegB0,
    output logic signed [11:0] o_RegX0,
    output logic signed [11:0] o_RegY0,
    output logic [10:0]        o_RegSizeW,
    output logic [9:0]         o_RegSizeH,
    output logic               o_activateFILL,
    input  logic               i_FILLInactiveNextCycle,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [2:0] {
        IDLE,
        GET_COL,
        GET_XY,
        GET_WH,
        ACTIVATE,
        WAIT_FILL
    } state_t;

    state_t      state;
    logic        in_get;
    logic [10:0] size_w_next;
    logic        unused_bits;

    // The opcode byte is never checked, and bits above the Y/H fields are ignored.
    assign unused_bits = ^i_fifoData[31:25];

    // The width field is rounded up to a multiple of 16 in 11 bits, so 0x3FF becomes 0x400.
    assign size_w_next = ({1'b0, i_fifoData[9:0]} + 11'd15) & 11'h7F0;

    assign in_get    = (state == GET_COL) || (state == GET_XY) || (state == GET_WH);
    // A word is consumed on the same edge that latches it, and never from an empty FIFO.
    assign o_fifoPop = in_get && !i_fifoEmpty;
    assign o_busy    = (state != IDLE) || o_done;

    // Packet sequencing, setup-register capture, and the activate/done pulses.
    always_ff @(posedge i_clk) begin
        // NOTE: every register in this block uses <= so all of them update from
        // the same pre-edge values, whatever order the statements appear in.
        if (!i_nrst) begin
            state          <= IDLE;
            o_RegR0        <= '0;
            o_RegG0        <= '0;
            o_RegB0        <= '0;
            o_RegX0        <= '0;
            o_RegY0        <= '0;
            o_RegSizeW     <= '0;
            o_RegSizeH     <= '0;
            o_activateFILL <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            o_activateFILL <= 1'b0;
            o_done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state <= GET_COL;
                    end
                end
                GET_COL: begin
                    if (!i_fifoEmpty) begin
                        o_RegR0 <= i_fifoData[7:0];
                        o_RegG0 <= i_fifoData[15:8];
                        o_RegB0 <= i_fifoData[23:16];
                        state   <= GET_XY;
                    end
                end
                GET_XY: begin
                    if (!i_fifoEmpty) begin
                        o_RegX0 <= {2'b00, i_fifoData[9:4], 4'b0000};
                        o_RegY0 <= {3'b000, i_fifoData[24:16]};
                        state   <= GET_WH;
                    end
                end
                GET_WH: begin
                    if (!i_fifoEmpty) begin
                        o_RegSizeW     <= size_w_next;
                        o_RegSizeH     <= {1'b0, i_fifoData[24:16]};
                        o_activateFILL <= 1'b1;
                        state          <= ACTIVATE;
                    end
                end
                ACTIVATE: begin
                    state <= WAIT_FILL;
                end
                WAIT_FILL: begin
                    // Done lands one cycle later, when the fill engine is already idle.
                    if (i_FILLInactiveNextCycle) begin
                        o_done <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_fill_cmd_loader.sv
// Testbench for gpu_fill_cmd_loader. A FIFO model feeds packet words, and a stub
// fill engine returns the completion strobe. A monitor checks every activate pulse
// and every done pulse against expectations queued when stimulus is issued.
`timescale 1ns/1ps
module tb_gpu_fill_cmd_loader;

    logic               i_clk = 1'b0;
    logic               i_nrst = 1'b0;
    logic               i_start = 1'b0;
    logic [31:0]        i_fifoData = 32'h0;
    logic               i_fifoEmpty = 1'b1;
    logic               i_FILLInactiveNextCycle = 1'b0;
    logic               o_fifoPop;
    logic [7:0]         o_RegR0, o_RegG0, o_RegB0;
    logic signed [11:0] o_RegX0, o_RegY0;
    logic [10:0]        o_RegSizeW;
    logic [9:0]         o_RegSizeH;
    logic               o_activateFILL, o_busy, o_done;

    gpu_fill_cmd_loader dut (
        .i_clk                  (i_clk),
        .i_nrst                 (i_nrst),
        .i_start                (i_start),
        .i_fifoData             (i_fifoData),
        .i_fifoEmpty            (i_fifoEmpty),
        .o_fifoPop              (o_fifoPop),
        .o_RegR0                (o_RegR0),
        .o_RegG0                (o_RegG0),
        .o_RegB0                (o_RegB0),
        .o_RegX0                (o_RegX0),
        .o_RegY0                (o_RegY0),
        .o_RegSizeW             (o_RegSizeW),
        .o_RegSizeH             (o_RegSizeH),
        .o_activateFILL         (o_activateFILL),
        .i_FILLInactiveNextCycle(i_FILLInactiveNextCycle),
        .o_busy                 (o_busy),
        .o_done                 (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  r, g, b;
        logic [11:0] x0, y0;
        logic [10:0] w;
        logic [9:0]  h;
        int          act_cyc;   // -1 when the activate cycle is not predicted
    } fill_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] fifo_q[$];
    int          gap_len  = 0;
    int          gap_cnt  = 0;
    logic        pending_pop = 1'b0;
    fill_t       exp_fill_q[$];
    int          exp_done_q[$];
    fill_t       last_e;
    fill_t       mon_e;
    int          mon_d;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic from the packet rules.
    function automatic fill_t model(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        fill_t e;
        int    f;
        e.r  = 8'(w0 % 256);
        e.g  = 8'((w0 / 256) % 256);
        e.b  = 8'((w0 / 65536) % 256);
        e.x0 = 12'(((w1 / 16) % 64) * 16);
        e.y0 = 12'((w1 / 65536) % 512);
        f    = int'(w2 % 1024);
        e.w  = 11'(((f + 15) / 16) * 16);
        e.h  = 10'((w2 / 65536) % 512);
        e.act_cyc = -1;
        return e;
    endfunction

    // FIFO model: the head is presented just after each falling edge. A pop
    // observed at a rising edge removes the head and opens a programmable gap.
    initial forever begin
        @(negedge i_clk);
        #1;
        if (pending_pop) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            gap_cnt = gap_len;
        end else if (gap_cnt > 0) begin
            gap_cnt--;
        end
        i_fifoEmpty = (fifo_q.size() == 0) || (gap_cnt > 0);
        i_fifoData  = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF;
        #3;
        pending_pop = o_fifoPop;
        if (o_fifoPop) check("pop_only_when_nonempty", {31'b0, i_fifoEmpty}, 0);
    end

    // Monitor: consumes scoreboard entries whenever the DUT pulses activate or done.
    initial forever begin
        @(posedge i_clk);
        #1;
        if (o_activateFILL) begin
            if (exp_fill_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_activate: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e  = exp_fill_q.pop_front();
                last_e = mon_e;
                check("R0", {24'b0, o_RegR0}, {24'b0, mon_e.r});
                check("G0", {24'b0, o_RegG0}, {24'b0, mon_e.g});
                check("B0", {24'b0, o_RegB0}, {24'b0, mon_e.b});
                check("X0", {20'b0, o_RegX0}, {20'b0, mon_e.x0});
                check("Y0", {20'b0, o_RegY0}, {20'b0, mon_e.y0});
                check("SizeW", {21'b0, o_RegSizeW}, {21'b0, mon_e.w});
                check("SizeH", {22'b0, o_RegSizeH}, {22'b0, mon_e.h});
                if (mon_e.act_cyc >= 0) check("activate_cycle", cyc, mon_e.act_cyc);
            end
        end
        if (o_done) begin
            if (exp_done_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
                mon_d = exp_done_q.pop_front();
                check("done_cycle", cyc, mon_d);
                check("busy_with_done", {31'b0, o_busy}, 1);
                check("hold_X0_at_done", {20'b0, o_RegX0}, {20'b0, last_e.x0});
                check("hold_SizeW_at_done", {21'b0, o_RegSizeW}, {21'b0, last_e.w});
                check("hold_SizeH_at_done", {22'b0, o_RegSizeH}, {22'b0, last_e.h});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_state_busy"}, {31'b0, o_busy}, 0);
        check({tag, "_done"}, {31'b0, o_done}, 0);
        check({tag, "_activate"}, {31'b0, o_activateFILL}, 0);
        check({tag, "_pop"}, {31'b0, o_fifoPop}, 0);
        check({tag, "_R0"}, {24'b0, o_RegR0}, 0);
        check({tag, "_G0"}, {24'b0, o_RegG0}, 0);
        check({tag, "_B0"}, {24'b0, o_RegB0}, 0);
        check({tag, "_X0"}, {20'b0, o_RegX0}, 0);
        check({tag, "_Y0"}, {20'b0, o_RegY0}, 0);
        check({tag, "_SizeW"}, {21'b0, o_RegSizeW}, 0);
        check({tag, "_SizeH"}, {22'b0, o_RegSizeH}, 0);
    endtask

    task automatic wait_activate();
        for (int k = 0; k < 200 && !o_activateFILL; k++) @(negedge i_clk);
        check("activate_seen", {31'b0, o_activateFILL}, 1);
    endtask

    task automatic idle_check();
        @(negedge i_clk);
        check("idle_busy", {31'b0, o_busy}, 0);
        check("idle_activate", {31'b0, o_activateFILL}, 0);
    endtask

    // Issue one packet and run it to completion. The task returns at the falling
    // edge where o_done is high, so a caller can start the next packet at once.
    task automatic run_packet(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                              input int g, input int fdly, input bit spur_start, input bit spur_inact);
        fill_t e;
        gap_len = g;
        gap_cnt = g;
        fifo_q.push_back(w0);
        if (!spur_inact) begin
            fifo_q.push_back(w1);
            fifo_q.push_back(w2);
        end
        e = model(w0, w1, w2);
        e.act_cyc = (g == 0 && !spur_inact) ? cyc + 4 : -1;
        exp_fill_q.push_back(e);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        if (spur_inact) begin
            // Only word0 is present, so the loader is stalled in GET_XY here.
            repeat (g + 4) @(negedge i_clk);
            i_FILLInactiveNextCycle = 1'b1;
            @(negedge i_clk);
            i_FILLInactiveNextCycle = 1'b0;
            check("busy_after_spurious_inactive", {31'b0, o_busy}, 1);
            check("R0_after_spurious_inactive", {24'b0, o_RegR0}, {24'b0, e.r});
            fifo_q.push_back(w1);
            fifo_q.push_back(w2);
        end
        wait_activate();
        @(negedge i_clk);
        check("busy_in_wait_fill", {31'b0, o_busy}, 1);
        if (spur_start) begin
            i_start = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
        end
        repeat (fdly) @(negedge i_clk);
        i_FILLInactiveNextCycle = 1'b1;
        exp_done_q.push_back(cyc + 1);
        @(negedge i_clk);
        i_FILLInactiveNextCycle = 1'b0;
        for (int k = 0; k < 50 && exp_done_q.size() != 0; k++) @(negedge i_clk);
        check("done_seen", exp_done_q.size(), 0);
        exp_done_q.delete();
        check("fifo_drained", fifo_q.size(), 0);
        check("hold_R0_after", {24'b0, o_RegR0}, {24'b0, e.r});
        check("hold_Y0_after", {20'b0, o_RegY0}, {20'b0, e.y0});
        check("hold_SizeW_after", {21'b0, o_RegSizeW}, {21'b0, e.w});
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge i_clk);
        check_all_zero("reset");
        i_nrst = 1'b1;
        @(negedge i_clk);

        // Basic packet with a prefilled FIFO
        run_packet(32'h0211_2233, 32'h0020_0035, 32'h0010_001F, 0, 2, 1'b0, 1'b0);
        idle_check();

        // Coordinate masking and width rounding to 0x400
        run_packet(32'h02AB_CDEF, 32'hFFFF_FFFF, 32'hFFFF_03FF, 0, 0, 1'b0, 1'b0);
        idle_check();

        // Exact multiple of 16, then zero width and height
        run_packet(32'h0201_0203, 32'h0000_0000, 32'h0005_0010, 0, 1, 1'b0, 1'b0);
        idle_check();
        run_packet(32'h0200_0000, 32'h0010_0010, 32'h0000_0000, 0, 0, 1'b0, 1'b0);
        idle_check();

        // Three empty cycles before each word
        run_packet(32'h0211_2233, 32'h0020_0035, 32'h0010_001F, 3, 1, 1'b0, 1'b0);
        idle_check();

        // Reset during WAIT_FILL abandons the fill without a done pulse
        gap_len = 0;
        fifo_q.push_back(32'h0299_AABB);
        fifo_q.push_back(32'h0100_0200);
        fifo_q.push_back(32'h0040_0040);
        exp_fill_q.push_back(model(32'h0299_AABB, 32'h0100_0200, 32'h0040_0040));
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_activate();
        @(negedge i_clk);
        i_nrst = 1'b0;
        @(posedge i_clk);
        #1;
        check_all_zero("midreset");
        @(negedge i_clk);
        i_nrst = 1'b1;
        repeat (5) @(negedge i_clk);
        check("no_done_after_reset", {31'b0, o_busy}, 0);

        // A fresh packet after the reset
        run_packet(32'h0244_5566, 32'h0123_0457, 32'h00FF_0123, 0, 2, 1'b0, 1'b0);
        idle_check();

        // Spurious start in WAIT_FILL and spurious inactive strobe in GET_XY
        run_packet(32'h0277_8899, 32'h0040_0080, 32'h0030_0040, 0, 3, 1'b1, 1'b1);
        idle_check();

        // Back-to-back: the next start lands in the done cycle
        run_packet(32'h0201_0101, 32'h0002_0020, 32'h0003_0030, 0, 0, 1'b0, 1'b0);
        run_packet(32'h0202_0202, 32'h0004_0040, 32'h0005_0050, 0, 1, 1'b0, 1'b0);
        idle_check();

        // Randomised packets
        for (int i = 0; i < 12; i++) begin
            logic [31:0] w0, w1, w2;
            bit          b2b;
            w0  = $urandom;
            w1  = $urandom;
            w2  = $urandom;
            b2b = 1'($urandom_range(0, 1));
            run_packet(w0, w1, w2, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (!b2b) idle_check();
        end

        repeat (5) @(negedge i_clk);
        check("scoreboard_empty", exp_fill_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
